// File: rtl/mem_wb_register_if.sv
// MEM -> WB boundary bundle: the MEM-stage capture inputs, the registered write-back/forwarding
// outputs, and the upstream stall request. The MEM side drives through "master"; the register is "slave".
interface mem_wb_register_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
);
  logic              Stall;
  logic              Flush;
  logic              MemValid;
  logic              MemReady;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] AddressIn;
  logic              MuxController;
  logic [1:0]        DataSize;
  logic              SignedLoad;
  logic              RegWriteIn;
  logic [REG_W-1:0]  RdIn;

  logic [DATA_W-1:0] WbData;
  logic [REG_W-1:0]  WbRd;
  logic              WbRegWrite;
  logic              WbValid;
  logic              AlignFault;
  logic              StallReq;
  logic [CNT_W-1:0]  RetireCount;

  modport master (
    output Stall, Flush, MemValid, MemReady, DataIn, AddressIn,
           MuxController, DataSize, SignedLoad, RegWriteIn, RdIn,
    input  WbData, WbRd, WbRegWrite, WbValid, AlignFault, StallReq, RetireCount
  );

  modport slave (
    input  Stall, Flush, MemValid, MemReady, DataIn, AddressIn,
           MuxController, DataSize, SignedLoad, RegWriteIn, RdIn,
    output WbData, WbRd, WbRegWrite, WbValid, AlignFault, StallReq, RetireCount
  );
endinterface

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: formats the raw load word (lane select + extension), flags misaligned
// loads, and presents a registered write-back/forwarding port plus a retired-instruction counter.
module mem_wb_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input logic            Clk,
  input logic            ResetN,
  mem_wb_register_if.slave bus
);

  // What the register does on the coming edge, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2
  } act_e;

  logic [1:0]        addr_lo;
  logic [7:0]        byte_lane [4];
  logic [15:0]       half_lane [2];
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_fmt;
  logic [DATA_W-1:0] sel_val;
  logic              misalign;
  act_e              action;

  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic [REG_W-1:0]  wb_rd_d, wb_rd_q;
  logic              wb_reg_write_d, wb_reg_write_q;
  logic              wb_valid_d, wb_valid_q;
  logic              align_fault_d, align_fault_q;
  logic [CNT_W-1:0]  retire_cnt_d, retire_cnt_q;

  assign addr_lo = bus.AddressIn[1:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign byte_lane[gi] = bus.DataIn[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
    assign half_lane[gi] = bus.DataIn[16*gi +: 16];
  end

  always_comb begin
    byte_sel = byte_lane[addr_lo];
    half_sel = half_lane[addr_lo[1]];
    case (bus.DataSize)
      2'b00:   load_fmt = {{(DATA_W-8){bus.SignedLoad & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{(DATA_W-16){bus.SignedLoad & half_sel[15]}}, half_sel};
      default: load_fmt = bus.DataIn;
    endcase
  end

  // Byte loads can never be misaligned; encoding 11 is checked like a word.
  always_comb begin
    misalign = 1'b0;
    if (bus.MuxController) begin
      if (bus.DataSize == 2'b01)
        misalign = addr_lo[0];
      else if (bus.DataSize[1])
        misalign = (addr_lo != 2'b00);
    end
  end

  assign sel_val = bus.MuxController ? load_fmt : bus.AddressIn;

  // Flush beats Stall; Stall beats an incomplete memory access.
  always_comb begin
    action = ACT_CAPTURE;
    if (bus.Flush)
      action = ACT_BUBBLE;
    else if (bus.Stall)
      action = ACT_HOLD;
    else if (!(bus.MemValid && bus.MemReady))
      action = ACT_BUBBLE;
  end

  always_comb begin
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_valid_d     = wb_valid_q;
    align_fault_d  = align_fault_q;
    retire_cnt_d   = retire_cnt_q;
    case (action)
      ACT_BUBBLE: begin
        wb_data_d      = '0;
        wb_rd_d        = '0;
        wb_reg_write_d = 1'b0;
        wb_valid_d     = 1'b0;
        align_fault_d  = 1'b0;
      end
      ACT_CAPTURE: begin
        // A faulting load still retires, but must not write or forward data.
        wb_data_d      = misalign ? '0 : sel_val;
        wb_rd_d        = bus.RdIn;
        wb_reg_write_d = bus.RegWriteIn & ~misalign;
        wb_valid_d     = 1'b1;
        align_fault_d  = misalign;
        retire_cnt_d   = retire_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      align_fault_q  <= 1'b0;
      retire_cnt_q   <= '0;
    end else begin
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_valid_q     <= wb_valid_d;
      align_fault_q  <= align_fault_d;
      retire_cnt_q   <= retire_cnt_d;
    end
  end

  assign bus.WbData      = wb_data_q;
  assign bus.WbRd        = wb_rd_q;
  assign bus.WbRegWrite  = wb_reg_write_q;
  assign bus.WbValid     = wb_valid_q;
  assign bus.AlignFault  = align_fault_q;
  assign bus.RetireCount = retire_cnt_q;
  assign bus.StallReq    = bus.MemValid & ~bus.MemReady;

endmodule
